// File: rtl/i281_pkg.sv
// Shared definitions for the i281 fetch stage: FSM state codes,
// instruction word width and code-ROM bank geometry.
package i281_pkg;

  localparam int I281_INSTR_W    = 16;
  localparam int I281_BANK_WORDS = 16;
  localparam int I281_BANK_W     = I281_INSTR_W * I281_BANK_WORDS;

  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_RUN  = 2'd1;
  localparam logic [1:0] FETCH_STOP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = FETCH_IDLE,
    ST_RUN  = FETCH_RUN,
    ST_STOP = FETCH_STOP
  } fetch_state_e;

endpackage

// File: rtl/i281_fetch_unit_if.sv
// Fetch-to-decode link: the instruction handshake plus the redirect path
// coming back from decode/execute.
//
// Handshake: the fetch side holds instr/instr_pc stable while
// instr_valid=1 and instr_ready=0; a word is transferred on any rising
// edge where instr_valid && instr_ready. instr_ready may depend on
// instr_valid but instr_valid never depends on instr_ready.
interface i281_fetch_unit_if #(
  parameter int PC_W = 5
);
  import i281_pkg::*;

  logic [I281_INSTR_W-1:0] instr;
  logic [PC_W-1:0]         instr_pc;
  logic                    instr_valid;
  logic                    instr_ready;
  logic                    redirect_valid;
  logic [PC_W-1:0]         redirect_pc;

  modport master (
    output instr, instr_pc, instr_valid,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  instr, instr_pc, instr_valid,
    output instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/i281_bank_mux.sv
// Combinational word select from the two flattened code banks:
// pc[4] picks the bank, pc[3:0] picks the 16-bit word inside it.
module i281_bank_mux
  import i281_pkg::*;
#(
  parameter int PC_W = 5
) (
  input  logic [I281_BANK_W-1:0]  code_low,
  input  logic [I281_BANK_W-1:0]  code_high,
  input  logic [PC_W-1:0]         pc,
  output logic [I281_INSTR_W-1:0] word
);

  logic [I281_BANK_W-1:0] bank;
  logic [3:0]             idx;

  assign idx = pc[3:0];

  // Pick the bank, then slice out the addressed word.
  always_comb begin
    bank = pc[4] ? code_high : code_low;
    word = bank[{idx, 4'b0000} +: I281_INSTR_W];
  end

endmodule

// File: rtl/i281_fetch_unit.sv
// i281 instruction-fetch stage: program counter, bank select, instruction
// register and IDLE/RUN/STOP control. Redirects flush the in-flight word.
// Optional accepted-instruction counter: define I281_FETCH_PERF_EN.
module i281_fetch_unit
  import i281_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter bit WRAP_HALT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [I281_BANK_W-1:0] code_low,
  input  logic [I281_BANK_W-1:0] code_high,
  input  logic                   start,
  input  logic                   halt_req,
  i281_fetch_unit_if.master      fif,
  output logic [PC_W-1:0]        pc,
  output logic [1:0]             state,
  output logic [15:0]            fetch_count
);

  fetch_state_e            state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [I281_INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]         ipc_q, ipc_d;
  logic                    valid_q, valid_d;

  logic [I281_INSTR_W-1:0] word;
  logic                    hs;
  logic                    last_accept;

  i281_bank_mux #(.PC_W(PC_W)) u_bank_mux (
    .code_low  (code_low),
    .code_high (code_high),
    .pc        (pc_q),
    .word      (word)
  );

  assign hs          = valid_q && fif.instr_ready;
  assign last_accept = (WRAP_HALT == 1'b1) && hs && (ipc_q == {PC_W{1'b1}});

  // Next-state, PC and instruction register; redirect beats fetch, halt beats redirect.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_STOP;
          if (fif.redirect_valid) begin
            pc_d    = fif.redirect_pc;
            valid_d = 1'b0;
          end else if (hs) begin
            valid_d = 1'b0;
          end
        end else if (fif.redirect_valid) begin
          pc_d    = fif.redirect_pc;
          valid_d = 1'b0;
        end else if (last_accept) begin
          state_d = ST_STOP;
          valid_d = 1'b0;
        end else if (!valid_q || fif.instr_ready) begin
          instr_d = word;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_W'(1);
        end
      end
      ST_STOP: begin
        // Let a pending word drain, never fetch again.
        if (hs) valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign fif.instr       = instr_q;
  assign fif.instr_pc    = ipc_q;
  assign fif.instr_valid = valid_q;
  assign pc              = pc_q;
  assign state           = state_q;

`ifdef I281_FETCH_PERF_EN
  logic [15:0] count_q;

  // Saturating count of accepted instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (hs && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_i281_fetch_unit.sv
// Bench for i281_fetch_unit: scoreboard of expected {pc, word} pairs popped
// on each handshake, a table of redirect targets, and hand-written
// sequences for stall, wrap-to-STOP, halt+redirect and mid-run reset.
module tb_i281_fetch_unit;
  import i281_pkg::*;

  localparam int PC_W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] code_low;
  logic [255:0] code_high;
  logic         start;
  logic         halt_req;
  logic [4:0]   pc;
  logic [1:0]   state;
  logic [15:0]  fetch_count;

  i281_fetch_unit_if #(.PC_W(PC_W)) fif ();

  i281_fetch_unit #(.PC_W(PC_W), .WRAP_HALT(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .code_low    (code_low),
    .code_high   (code_high),
    .start       (start),
    .halt_req    (halt_req),
    .fif         (fif),
    .pc          (pc),
    .state       (state),
    .fetch_count (fetch_count)
  );

  // Clock
  always #5 clk = ~clk;

  logic [15:0] mem [32];
  logic [20:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          acc_cnt  = 0;

  typedef struct {
    logic [4:0]  target;
    logic [15:0] exp_word;
    logic [4:0]  exp_next;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample the handshake at negedge, then step past the posedge.
  task automatic cyc();
    logic [20:0] e;
    @(negedge clk);
    if (!rst && fif.instr_valid && fif.instr_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got pc %0d word %0h expected no transfer",
                 fif.instr_pc, fif.instr);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", {11'b0, fif.instr_pc, fif.instr}, {11'b0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int a, input int b);
    for (int i = a; i <= b; i++) exp_q.push_back({5'(i), mem[i]});
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    start              = 1'b0;
    halt_req           = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = '0;
    fif.instr_ready    = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    rst     = 1'b0;
    acc_cnt = 0;
  endtask

  task automatic check_perf(input string name);
`ifdef I281_FETCH_PERF_EN
    check(name, {16'b0, fetch_count}, acc_cnt);
`else
    check(name, {16'b0, fetch_count}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    for (int k = 0; k < 32; k++) mem[k] = 16'($urandom_range(0, 65535));
    mem[0] = 16'h3000;
    mem[1] = 16'hA005;
    for (int k = 0; k < 16; k++) begin
      code_low[16*k +: 16]  = mem[k];
      code_high[16*k +: 16] = mem[16+k];
    end
    vecs[0].target = 5'd15;
    vecs[1].target = 5'd16;
    vecs[2].target = 5'd0;
    vecs[3].target = 5'd31;
    vecs[4].target = 5'd5;
    vecs[5].target = 5'd20;
    for (int i = 0; i < 6; i++) begin
      vecs[i].exp_word = mem[vecs[i].target];
      vecs[i].exp_next = vecs[i].target + 5'd1;
    end

    // Reset values
    do_reset();
    check("rst_pc", pc, 0);
    check("rst_instr", fif.instr, 0);
    check("rst_instr_pc", fif.instr_pc, 0);
    check("rst_valid", fif.instr_valid, 0);
    check("rst_state", state, FETCH_IDLE);
    check("rst_count", fetch_count, 0);

    // IDLE ignores redirect and halt
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 5'd9;
    halt_req           = 1'b1;
    cyc();
    fif.redirect_valid = 1'b0;
    halt_req           = 1'b0;
    check("idle_state", state, FETCH_IDLE);
    check("idle_pc", pc, 0);

    // Sequential fetch
    push_range(0, 4);
    fif.instr_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("run_entry_state", state, FETCH_RUN);
    check("run_entry_valid", fif.instr_valid, 0);
    cyc();
    check("seq0_valid", fif.instr_valid, 1);
    check("seq0_instr", fif.instr, 16'h3000);
    check("seq0_pc", fif.instr_pc, 0);
    check("seq0_next_pc", pc, 1);
    cyc();
    check("seq1_instr", fif.instr, 16'hA005);
    check("seq1_pc", fif.instr_pc, 1);
    cyc();
    check("seq2_pc", fif.instr_pc, 2);

    // Backpressure at instr_pc=2
    fif.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_instr_pc", fif.instr_pc, 2);
      check("stall_instr", fif.instr, mem[2]);
      check("stall_pc", pc, 3);
      check("stall_valid", fif.instr_valid, 1);
    end
    check_perf("perf_stall");
    fif.instr_ready = 1'b1;
    cyc();
    check("release_instr_pc", fif.instr_pc, 3);
    check("release_pc", pc, 4);
    cyc();
    check("seq4_pc", fif.instr_pc, 4);

    // Redirect to 7 while pc 4 is accepted
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 5'd7;
    cyc();
    fif.redirect_valid = 1'b0;
    check("redir_flush", fif.instr_valid, 0);
    check("redir_pc", pc, 7);
    check("redir_state", state, FETCH_RUN);
    exp_q.delete();
    push_range(7, 7);
    fif.instr_ready = 1'b0;
    cyc();
    check("redir_valid", fif.instr_valid, 1);
    check("redir_instr_pc", fif.instr_pc, 7);
    check("redir_instr", fif.instr, mem[7]);
    check_perf("perf_after_redirect");

    // Table of redirect targets, both banks and the ends of the space
    for (int i = 0; i < 6; i++) begin
      fif.redirect_valid = 1'b1;
      fif.redirect_pc    = vecs[i].target;
      cyc();
      fif.redirect_valid = 1'b0;
      check("vec_flush", fif.instr_valid, 0);
      check("vec_pc", pc, vecs[i].target);
      cyc();
      check("vec_valid", fif.instr_valid, 1);
      check("vec_instr_pc", fif.instr_pc, vecs[i].target);
      check("vec_instr", fif.instr, vecs[i].exp_word);
      check("vec_next_pc", pc, vecs[i].exp_next);
    end

    // Stream 13..31 across the bank boundary into wrap-halt
    exp_q.delete();
    push_range(13, 31);
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 5'd13;
    cyc();
    fif.redirect_valid = 1'b0;
    fif.instr_ready    = 1'b1;
    cyc();
    guard = 0;
    while (state != FETCH_STOP && guard < 40) begin
      cyc();
      guard++;
      if (fif.instr_valid && fif.instr_pc == 5'd16) check("bank_cross", fif.instr, mem[16]);
    end
    check("wrap_stop_state", state, FETCH_STOP);
    check("wrap_all_accepted", exp_q.size(), 0);
    check("wrap_valid", fif.instr_valid, 0);
    check("wrap_pc", pc, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("stop_ignores_start", state, FETCH_STOP);
    check("stop_no_fetch", fif.instr_valid, 0);
    check_perf("perf_wrap");

    // halt_req together with redirect
    do_reset();
    push_range(0, 3);
    fif.instr_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    fif.instr_ready    = 1'b0;
    halt_req           = 1'b1;
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 5'd9;
    cyc();
    halt_req           = 1'b0;
    fif.redirect_valid = 1'b0;
    check("halt_redir_state", state, FETCH_STOP);
    check("halt_redir_valid", fif.instr_valid, 0);
    check("halt_redir_pc", pc, 9);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("halt_start_ignored", state, FETCH_STOP);
    check("halt_pc_held", pc, 9);

    // halt_req alone: pending word drains, no further fetch
    do_reset();
    push_range(0, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    fif.instr_ready = 1'b1;
    cyc();
    check("halt_state", state, FETCH_STOP);
    check("halt_drained", fif.instr_valid, 0);
    check("halt_pc", pc, 1);

    // Reset in the middle of a run
    do_reset();
    push_range(0, 5);
    fif.instr_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    check("midrst_pc", pc, 0);
    check("midrst_state", state, FETCH_IDLE);
    check("midrst_valid", fif.instr_valid, 0);
    check("midrst_instr", fif.instr, 0);
    check("midrst_instr_pc", fif.instr_pc, 0);
    check("midrst_count", fetch_count, 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
